egg_countdown_core: RTL and testbench

- MM:SS BCD countdown engine for the egg timer.
- Sits directly upstream of the display path. Its four BCD digit outputs go through the digit scan mux into the BCD-to-7-segment decoder.
- Handles time setting, start/pause, 1 Hz countdown with minute borrow, and the end-of-count alarm flag.
- All digit outputs stay legal BCD (0-9) at all times, so the decoder's blank default is never hit.

---
 rtl/egg_countdown_core.sv | 133 +++++++++++++
 tb/tb_egg_countdown_core.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/egg_countdown_core.sv
// MM:SS BCD countdown engine for the egg timer: time setting, start/pause,
// 1 Hz countdown with minute borrow, and an end-of-count alarm flag.
module egg_countdown_core #(
    parameter int TICK_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_min,
    input  logic       inc_sec,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        st, st_nxt;
    logic [PW-1:0] pre, pre_nxt;
    logic [3:0]    mt_n, mo_n, stn, so_n;

    logic          tick, time_zero, dec_zero;
    logic [3:0]    imt, imo, ist, iso;
    logic [3:0]    dmt, dmo, dst, dso;
    logic          b_s1, b_s2, b_m;

    assign tick      = (st == RUN) && (pre == PW'(TICK_CYCLES - 1));
    assign time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'd0);

    // BCD increments: minutes wrap 99->00, seconds wrap 59->00 without carry
    assign imo = (min_ones == 4'd9) ? 4'd0 : min_ones + 4'd1;
    assign imt = (min_ones == 4'd9) ? ((min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1) : min_tens;
    assign iso = (sec_ones == 4'd9) ? 4'd0 : sec_ones + 4'd1;
    assign ist = (sec_ones == 4'd9) ? ((sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1) : sec_tens;

    // Borrow chain; only used in RUN, where time is never 00:00
    assign b_s1     = (sec_ones == 4'd0);
    assign dso      = b_s1 ? 4'd9 : sec_ones - 4'd1;
    assign dst      = b_s1 ? ((sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1) : sec_tens;
    assign b_s2     = b_s1 && (sec_tens == 4'd0);
    assign dmo      = b_s2 ? ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1) : min_ones;
    assign b_m      = b_s2 && (min_ones == 4'd0);
    assign dmt      = b_m ? min_tens - 4'd1 : min_tens;
    assign dec_zero = ({dmt, dmo, dst, dso} == 16'd0);

    always_comb begin
        st_nxt  = st;
        pre_nxt = pre;
        mt_n    = min_tens;
        mo_n    = min_ones;
        stn     = sec_tens;
        so_n    = sec_ones;
        case (st)
            IDLE: begin
                pre_nxt = '0;
                if (clear) begin
                    {mt_n, mo_n, stn, so_n} = '0;
                end else if (start_stop) begin
                    if (!time_zero) st_nxt = RUN;
                end else begin
                    if (inc_min) {mt_n, mo_n} = {imt, imo};
                    if (inc_sec) {stn, so_n} = {ist, iso};
                end
            end
            RUN: begin
                pre_nxt = tick ? '0 : pre + PW'(1);
                if (clear) begin
                    st_nxt                  = IDLE;
                    pre_nxt                 = '0;
                    {mt_n, mo_n, stn, so_n} = '0;
                end else begin
                    if (tick) {mt_n, mo_n, stn, so_n} = {dmt, dmo, dst, dso};
                    // reaching 00:00 outranks a coincident pause request
                    if (tick && dec_zero)  st_nxt = DONE;
                    else if (start_stop)   st_nxt = PAUSE;
                end
            end
            PAUSE: begin
                if (clear) begin
                    st_nxt                  = IDLE;
                    pre_nxt                 = '0;
                    {mt_n, mo_n, stn, so_n} = '0;
                end else if (start_stop) begin
                    st_nxt = RUN;
                end
            end
            DONE: begin
                if (clear || start_stop) begin
                    st_nxt  = IDLE;
                    pre_nxt = '0;
                end
            end
            default: st_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            pre      <= '0;
            min_tens <= 4'd0;
            min_ones <= 4'd0;
            sec_tens <= 4'd0;
            sec_ones <= 4'd0;
            running  <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            st       <= st_nxt;
            pre      <= pre_nxt;
            min_tens <= mt_n;
            min_ones <= mo_n;
            sec_tens <= stn;
            sec_ones <= so_n;
            running  <= (st_nxt == RUN);
            alarm    <= (st_nxt == DONE);
        end
    end

    assign state = st;

endmodule

// File: tb/tb_egg_countdown_core.sv
// Scoreboard bench for egg_countdown_core: a seconds-based reference model
// queues expected outputs per cycle; a monitor compares after each edge.
module tb_egg_countdown_core;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       inc_min = 1'b0, inc_sec = 1'b0, start_stop = 1'b0, clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm;
    logic [1:0] state;

    egg_countdown_core #(.TICK_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .inc_min(inc_min), .inc_sec(inc_sec), .start_stop(start_stop), .clear(clear),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    string phase = "init";

    logic [19:0] expq[$];
    string       tagq[$];

    // Reference model: minutes/seconds as plain integers, state as 0..3
    int m_min = 0, m_sec = 0, m_st = 0, m_pre = 0;

    function automatic logic [19:0] pack(int mm, int ss, int st);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                st == 1, st == 3, 2'(st)};
    endfunction

    function automatic logic [19:0] dut_snap();
        return {min_tens, min_ones, sec_tens, sec_ones, running, alarm, state};
    endfunction

    task automatic chk(string name, logic [19:0] act, logic [19:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h:%h%h:%h run=%b alm=%b st=%0d, want %h:%h%h:%h run=%b alm=%b st=%0d",
                      name, act[19:16], act[15:12], act[11:8], act[7:4], act[3], act[2], act[1:0],
                      exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1:0]);
    endtask

    task automatic model(bit im, bit is, bit ss, bit cl);
        int  t = m_min * 60 + m_sec;
        bit  tick = 0;
        int  nst = m_st;
        if (m_st == 1) begin
            if (m_pre == T - 1) begin tick = 1; m_pre = 0; end
            else m_pre++;
        end
        case (m_st)
            0: begin
                if (cl) begin m_min = 0; m_sec = 0; end
                else if (ss) begin if (t != 0) begin nst = 1; m_pre = 0; end end
                else begin
                    if (im) m_min = (m_min + 1) % 100;
                    if (is) m_sec = (m_sec + 1) % 60;
                end
            end
            1: begin
                if (cl) begin nst = 0; m_min = 0; m_sec = 0; m_pre = 0; end
                else begin
                    if (tick) begin t--; m_min = t / 60; m_sec = t % 60; end
                    if (tick && t == 0) nst = 3;
                    else if (ss)        nst = 2;
                end
            end
            2: begin
                if (cl) begin nst = 0; m_min = 0; m_sec = 0; m_pre = 0; end
                else if (ss) nst = 1;
            end
            default: if (cl || ss) begin nst = 0; m_pre = 0; end
        endcase
        m_st = nst;
    endtask

    // One clock cycle of stimulus; expected post-edge outputs go to the scoreboard
    task automatic step(bit im = 0, bit is = 0, bit ss = 0, bit cl = 0);
        @(negedge clk);
        inc_min = im; inc_sec = is; start_stop = ss; clear = cl;
        model(im, is, ss, cl);
        expq.push_back(pack(m_min, m_sec, m_st));
        tagq.push_back(phase);
        @(posedge clk);
        #2;
        inc_min = 0; inc_sec = 0; start_stop = 0; clear = 0;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Directed check against constants taken straight from the test plan
    task automatic expect_out(string name, int mm, int ss, int st);
        chk(name, dut_snap(), pack(mm, ss, st));
    endtask

    task automatic set_time(int mm, int ss);
        step(0, 0, 0, 1);
        for (int i = 0; i < mm; i++) step(1, 0, 0, 0);
        for (int i = 0; i < ss; i++) step(0, 1, 0, 0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) chk(tagq.pop_front(), dut_snap(), expq.pop_front());
        end
    end

    initial begin : stim
        #1 rst_n = 1'b0;
        #5;
        expect_out("reset_state", 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        phase = "sec_wrap60";
        for (int i = 0; i < 60; i++) step(0, 1);
        expect_out("sec_60_wraps", 0, 0, 0);
        phase = "sec_wrap59";
        for (int i = 0; i < 59; i++) step(0, 1);
        expect_out("sec_59", 0, 59, 0);
        step(0, 1);
        expect_out("sec_59_to_00", 0, 0, 0);
        phase = "min_wrap";
        for (int i = 0; i < 100; i++) step(1, 0);
        expect_out("min_100_wraps", 0, 0, 0);
        phase = "both_inc";
        step(1, 1);
        expect_out("both_inc", 1, 1, 0);

        phase = "start_at_zero";
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        expect_out("start_at_zero_ignored", 0, 0, 0);

        phase = "borrow";
        set_time(10, 0);
        step(0, 0, 1, 0);
        idle(3);
        expect_out("borrow_not_yet", 10, 0, 1);
        step();
        expect_out("borrow_0959", 9, 59, 1);
        idle(4);
        expect_out("borrow_0958", 9, 58, 1);

        phase = "to_zero";
        set_time(0, 2);
        step(0, 0, 1, 0);
        idle(4);
        expect_out("count_0001", 0, 1, 1);
        idle(4);
        expect_out("count_done", 0, 0, 3);
        step(1, 1);
        expect_out("inc_in_done_ignored", 0, 0, 3);
        step(0, 0, 1, 0);
        expect_out("done_ack", 0, 0, 0);

        phase = "pause";
        set_time(0, 5);
        step(0, 0, 1, 0);
        step();
        step(0, 0, 1, 0);
        idle(20);
        step(1, 1);
        expect_out("pause_frozen", 0, 5, 2);
        step(0, 0, 1, 0);
        step();
        expect_out("resume_not_yet", 0, 5, 1);
        step();
        expect_out("resume_0004", 0, 4, 1);
        step(1, 1);
        idle(11);
        expect_out("run_inc_ignored_0001", 0, 1, 1);
        idle(3);
        step(0, 0, 1, 0);
        expect_out("ss_on_tick_done", 0, 0, 3);
        step(0, 0, 0, 1);
        expect_out("done_clear", 0, 0, 0);

        phase = "clear_ss_run";
        set_time(1, 30);
        step(0, 0, 1, 0);
        idle(2);
        step(0, 0, 1, 1);
        expect_out("clear_beats_ss", 0, 0, 0);

        phase = "reset_run";
        set_time(1, 30);
        step(0, 0, 1, 0);
        idle(2);
        #1 rst_n = 1'b0;
        #1;
        expect_out("async_reset_mid_run", 0, 0, 0);
        m_min = 0; m_sec = 0; m_st = 0; m_pre = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        idle(3);
        expect_out("idle_after_reset", 0, 0, 0);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 31);
            case (r)
                0, 1, 2:  step(1, 0, 0, 0);
                3, 4, 5:  step(0, 1, 0, 0);
                6:        step(1, 1, 0, 0);
                7, 8:     step(0, 0, 1, 0);
                9:        step(0, 0, 0, ($urandom_range(0, 3) == 0));
                10:       step(0, 0, 1, ($urandom_range(0, 1) == 0));
                default:  step();
            endcase
        end

        repeat (3) @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
